// File: rtl/retro_catc_mem_arbiter.sv
// Purpose : round-robin share of one slow backing-memory port between NumReq requesters, one transaction in flight.
// Latency : ReqValid rise on an idle port -> RspValid after 3 cycles plus memory latency (IDLE, ISSUE, WAIT..MemAck, RESP).
// Backpressure: requesters hold ReqValid until their RspValid; Delay freezes the core clock-enable while anyone waits.
//
// Ports
//   Clk, Reset              core clock, synchronous active-high reset
//   ReqValid/ReqWrite       per-requester level request and direction
//   ReqAddr/ReqWData        packed per-requester address / write data (requester i at [i*W +: W])
//   RspValid/RspData/RspError  one-cycle completion pulse, read data, timeout-abort marker
//   MemReq/MemWrite/MemAddr/MemWData  registered request to the backing memory
//   MemAck/MemRData         one-cycle completion and read data from memory
//   Delay                   combinational stall request to CATC
//   StallClear/StallCount/TimeoutFlag  debug counters: saturating stall cycles, sticky timeout
module retro_catc_mem_arbiter #(
    parameter int NumReq        = 4,
    parameter int AddrWidth     = 24,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 4096,
    parameter int StallBits     = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NumReq-1:0]             ReqValid,
    input  logic [NumReq-1:0]             ReqWrite,
    input  logic [NumReq*AddrWidth-1:0]   ReqAddr,
    input  logic [NumReq*DataWidth-1:0]   ReqWData,
    output logic [NumReq-1:0]             RspValid,
    output logic [DataWidth-1:0]          RspData,
    output logic                          RspError,
    output logic                          MemReq,
    output logic                          MemWrite,
    output logic [AddrWidth-1:0]          MemAddr,
    output logic [DataWidth-1:0]          MemWData,
    input  logic                          MemAck,
    input  logic [DataWidth-1:0]          MemRData,
    output logic                          Delay,
    input  logic                          StallClear,
    output logic [StallBits-1:0]          StallCount,
    output logic                          TimeoutFlag
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_t;

    state_t            state;
    state_t            stateNext;

    logic [IdxW-1:0]   rrPtr;
    logic [IdxW-1:0]   grantIdx;
    logic [NumReq-1:0] shadow;
    logic [NumReq-1:0] elig;
    logic [NumReq-1:0] grantOneHot;
    logic [CntW-1:0]   toCnt;

    logic              pickVld;
    logic [IdxW-1:0]   pickIdx;

    logic              doGrant;
    logic              doAck;
    logic              doTimeout;
    logic              doResp;
    logic              cntClr;
    logic              cntInc;

    // The requester just served still shows ReqValid for one cycle after
    // its RspValid; the shadow mask keeps it from being granted again.
    assign elig        = ReqValid & ~shadow;
    assign grantOneHot = {{(NumReq-1){1'b0}}, 1'b1} << grantIdx;

    // Combinational so CATC drops its clock-enable in the same cycle a
    // request appears, not one cycle later.
    assign Delay    = (|elig) || (state != StIdle);
    assign RspValid = (state == StResp) ? grantOneHot : '0;

    // Round-robin pick: first eligible requester at or above rrPtr, wrapping.
    always_comb begin
        int cand;
        cand    = 0;
        pickVld = 1'b0;
        pickIdx = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = int'(rrPtr) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!pickVld && elig[cand]) begin
                pickVld = 1'b1;
                pickIdx = IdxW'(cand);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        doGrant   = 1'b0;
        doAck     = 1'b0;
        doTimeout = 1'b0;
        doResp    = 1'b0;
        cntClr    = 1'b0;
        cntInc    = 1'b0;
        case (state)
            StIdle: begin
                if (pickVld) begin
                    doGrant   = 1'b1;
                    stateNext = StIssue;
                end
            end
            StIssue: begin
                cntClr    = 1'b1;
                stateNext = StWait;
            end
            StWait: begin
                // An ack on the last permitted cycle still wins over the abort.
                if (MemAck) begin
                    doAck     = 1'b1;
                    stateNext = StResp;
                end else if (toCnt == CntLast) begin
                    doTimeout = 1'b1;
                    stateNext = StResp;
                end else begin
                    cntInc = 1'b1;
                end
            end
            StResp: begin
                doResp    = 1'b1;
                stateNext = StIdle;
            end
            default: begin
                stateNext = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rrPtr       <= '0;
            grantIdx    <= '0;
            shadow      <= '0;
            toCnt       <= '0;
            MemReq      <= 1'b0;
            MemWrite    <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            RspData     <= '0;
            RspError    <= 1'b0;
            StallCount  <= '0;
            TimeoutFlag <= 1'b0;
        end else begin
            if (doGrant) begin
                grantIdx <= pickIdx;
                MemReq   <= 1'b1;
                MemWrite <= ReqWrite[pickIdx];
                MemAddr  <= ReqAddr[int'(pickIdx)*AddrWidth +: AddrWidth];
                MemWData <= ReqWData[int'(pickIdx)*DataWidth +: DataWidth];
            end

            if (doAck || doTimeout) begin
                MemReq <= 1'b0;
            end

            if (cntClr) begin
                toCnt <= '0;
            end else if (cntInc) begin
                toCnt <= toCnt + CntW'(1);
            end

            // Writes return zero data so RspData never carries stale reads.
            if (doAck) begin
                RspData  <= MemWrite ? '0 : MemRData;
                RspError <= 1'b0;
            end else if (doTimeout) begin
                RspData  <= '0;
                RspError <= 1'b1;
            end

            shadow <= doResp ? grantOneHot : '0;

            if (doResp) begin
                rrPtr <= (grantIdx == IdxLast) ? '0 : grantIdx + IdxW'(1);
            end

            if (StallClear) begin
                StallCount <= '0;
            end else if (Delay && (StallCount != '1)) begin
                StallCount <= StallCount + StallBits'(1);
            end

            // A timeout in the same cycle as a clear leaves the flag set.
            if (doTimeout) begin
                TimeoutFlag <= 1'b1;
            end else if (StallClear) begin
                TimeoutFlag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_retro_catc_mem_arbiter.sv
// Purpose : directed self-checking bench for retro_catc_mem_arbiter.
// Latency : checks are sampled 1 time unit after each rising Clk edge.
// Backpressure: the bench plays both the requesters and the backing memory.
module tb_retro_catc_mem_arbiter;

    localparam int NumReq = 4;
    localparam int AW     = 24;
    localparam int DW     = 16;
    localparam int TO     = 16;
    localparam int SB     = 16;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic [NumReq-1:0]    ReqValid;
    logic [NumReq-1:0]    ReqWrite;
    logic [NumReq*AW-1:0] ReqAddr;
    logic [NumReq*DW-1:0] ReqWData;
    logic [NumReq-1:0]    RspValid;
    logic [DW-1:0]        RspData;
    logic                 RspError;
    logic                 MemReq;
    logic                 MemWrite;
    logic [AW-1:0]        MemAddr;
    logic [DW-1:0]        MemWData;
    logic                 MemAck;
    logic [DW-1:0]        MemRData;
    logic                 Delay;
    logic                 StallClear;
    logic [SB-1:0]        StallCount;
    logic                 TimeoutFlag;

    int checks = 0;
    int errors = 0;

    retro_catc_mem_arbiter #(
        .NumReq(NumReq), .AddrWidth(AW), .DataWidth(DW),
        .TimeoutCycles(TO), .StallBits(SB)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RspValid(RspValid), .RspData(RspData), .RspError(RspError),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData),
        .Delay(Delay),
        .StallClear(StallClear), .StallCount(StallCount), .TimeoutFlag(TimeoutFlag)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        Reset    = 1'b1;
        ReqValid = '0;
        MemAck   = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Starts in an IDLE cycle with the expected requester eligible; acks on
    // the first WAIT cycle; returns sampled in the RESP cycle.
    task automatic doTxn(input int idx, input logic [23:0] expAddr, input logic expWr,
                         input logic [15:0] expWData, input logic [15:0] ackData,
                         input logic [15:0] expRsp);
        tick();
        chk($sformatf("issue_memreq_%0d", idx), 32'(MemReq), 32'd1);
        chk($sformatf("issue_addr_%0d", idx), 32'(MemAddr), 32'(expAddr));
        chk($sformatf("issue_write_%0d", idx), 32'(MemWrite), 32'(expWr));
        if (expWr) chk($sformatf("issue_wdata_%0d", idx), 32'(MemWData), 32'(expWData));
        tick();
        chk($sformatf("wait_delay_%0d", idx), 32'(Delay), 32'd1);
        MemAck   = 1'b1;
        MemRData = ackData;
        tick();
        MemAck   = 1'b0;
        chk($sformatf("resp_valid_%0d", idx), 32'(RspValid), 32'(4'b0001 << idx));
        chk($sformatf("resp_data_%0d", idx), 32'(RspData), 32'(expRsp));
        chk($sformatf("resp_err_%0d", idx), 32'(RspError), 32'd0);
        chk($sformatf("resp_memreq_%0d", idx), 32'(MemReq), 32'd0);
    endtask

    initial begin
        Reset      = 1'b1;
        ReqValid   = '0;
        ReqWrite   = '0;
        ReqAddr    = '0;
        ReqWData   = '0;
        MemAck     = 1'b0;
        MemRData   = '0;
        StallClear = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            ReqAddr[i*AW +: AW] = 24'h100000 + 24'(i);
            ReqWData[i*DW +: DW] = 16'h1110 * 16'(i + 1);
        end

        // Reset state
        doReset();
        chk("rst_rspvalid", 32'(RspValid), 32'd0);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memaddr", 32'(MemAddr), 32'd0);
        chk("rst_delay", 32'(Delay), 32'd0);
        chk("rst_stall", 32'(StallCount), 32'd0);
        chk("rst_tflag", 32'(TimeoutFlag), 32'd0);

        // 1: single read on requester 2, ack 5 cycles after MemReq rises
        ReqAddr[2*AW +: AW] = 24'h001234;
        ReqValid = 4'b0100;
        #1;
        chk("t1_delay_idle", 32'(Delay), 32'd1);
        tick();
        chk("t1_memreq", 32'(MemReq), 32'd1);
        chk("t1_memaddr", 32'(MemAddr), 32'h001234);
        chk("t1_memwrite", 32'(MemWrite), 32'd0);
        repeat (4) tick();
        chk("t1_wait_memreq", 32'(MemReq), 32'd1);
        chk("t1_wait_norsp", 32'(RspValid), 32'd0);
        tick();
        MemAck   = 1'b1;
        MemRData = 16'hBEEF;
        tick();
        MemAck = 1'b0;
        chk("t1_rspvalid", 32'(RspValid), 32'b0100);
        chk("t1_rspdata", 32'(RspData), 32'hBEEF);
        chk("t1_delay_resp", 32'(Delay), 32'd1);
        tick();
        chk("t1_idle_rspvalid", 32'(RspValid), 32'd0);
        chk("t1_idle_delay", 32'(Delay), 32'd0);
        chk("t1_stall", 32'(StallCount), 32'd8);
        ReqValid = '0;
        ReqAddr[2*AW +: AW] = 24'h100002;

        // 2: four simultaneous requests from RR=0; requester 1 writes
        doReset();
        ReqWrite = 4'b0010;
        ReqValid = 4'b1111;
        doTxn(0, 24'h100000, 1'b0, 16'h0, 16'h0A0A, 16'h0A0A);
        tick();
        ReqValid[0] = 1'b0;
        chk("t2_delay_gap0", 32'(Delay), 32'd1);
        doTxn(1, 24'h100001, 1'b1, 16'h2220, 16'h7777, 16'h0000);
        tick();
        ReqValid[1] = 1'b0;
        chk("t2_delay_gap1", 32'(Delay), 32'd1);
        doTxn(2, 24'h100002, 1'b0, 16'h0, 16'h2222, 16'h2222);
        tick();
        ReqValid[2] = 1'b0;
        chk("t2_delay_gap2", 32'(Delay), 32'd1);
        doTxn(3, 24'h100003, 1'b0, 16'h0, 16'h3333, 16'h3333);
        tick();
        chk("t2_delay_after", 32'(Delay), 32'd0);
        chk("t2_stall", 32'(StallCount), 32'd16);
        ReqValid = '0;
        ReqWrite = '0;
        tick();
        // RR pointer wrapped to 0: requester 0 wins over 3
        ReqValid = 4'b1001;
        doTxn(0, 24'h100000, 1'b0, 16'h0, 16'h4444, 16'h4444);
        tick();
        ReqValid[0] = 1'b0;
        doTxn(3, 24'h100003, 1'b0, 16'h0, 16'h3333, 16'h3333);
        tick();
        ReqValid = '0;

        // 3: timeout, with StallClear landing on the abort cycle
        ReqValid = 4'b0001;
        tick();
        tick();
        repeat (TO - 1) tick();
        chk("t3_last_wait_memreq", 32'(MemReq), 32'd1);
        chk("t3_last_wait_norsp", 32'(RspValid), 32'd0);
        StallClear = 1'b1;
        tick();
        StallClear = 1'b0;
        chk("t3_rspvalid", 32'(RspValid), 32'b0001);
        chk("t3_rsperror", 32'(RspError), 32'd1);
        chk("t3_rspdata", 32'(RspData), 32'd0);
        chk("t3_tflag", 32'(TimeoutFlag), 32'd1);
        chk("t3_memreq", 32'(MemReq), 32'd0);
        chk("t3_stall_cleared", 32'(StallCount), 32'd0);
        tick();
        ReqValid = '0;
        chk("t3_stall_resume", 32'(StallCount), 32'd1);
        MemAck   = 1'b1;
        MemRData = 16'hDEAD;
        tick();
        MemAck = 1'b0;
        chk("t3_late_ack_norsp", 32'(RspValid), 32'd0);
        chk("t3_late_ack_memreq", 32'(MemReq), 32'd0);
        chk("t3_late_ack_delay", 32'(Delay), 32'd0);
        chk("t3_tflag_sticky", 32'(TimeoutFlag), 32'd1);

        // 4: reset while a write to requester 3 sits in WAIT
        ReqWrite = 4'b1000;
        ReqWData[3*DW +: DW] = 16'hA5A5;
        ReqValid = 4'b1000;
        tick();
        chk("t4_memwrite", 32'(MemWrite), 32'd1);
        tick();
        tick();
        Reset    = 1'b1;
        ReqValid = '0;
        tick();
        chk("t4_rst_memreq", 32'(MemReq), 32'd0);
        chk("t4_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("t4_rst_memaddr", 32'(MemAddr), 32'd0);
        chk("t4_rst_memwdata", 32'(MemWData), 32'd0);
        chk("t4_rst_rspvalid", 32'(RspValid), 32'd0);
        chk("t4_rst_rsperror", 32'(RspError), 32'd0);
        chk("t4_rst_tflag", 32'(TimeoutFlag), 32'd0);
        chk("t4_rst_stall", 32'(StallCount), 32'd0);
        Reset = 1'b0;
        tick();
        chk("t4_post_rst_delay", 32'(Delay), 32'd0);
        ReqValid = 4'b1000;
        doTxn(3, 24'h100003, 1'b1, 16'hA5A5, 16'h9999, 16'h0000);
        tick();
        ReqValid = '0;
        ReqWrite = '0;

        // 6: requester 1 holds ReqValid one cycle past RspValid
        ReqValid = 4'b0010;
        doTxn(1, 24'h100001, 1'b0, 16'h0, 16'h5A5A, 16'h5A5A);
        tick();
        chk("t6_shadow_delay", 32'(Delay), 32'd0);
        chk("t6_shadow_norsp", 32'(RspValid), 32'd0);
        tick();
        chk("t6_no_regrant", 32'(MemReq), 32'd0);
        ReqValid = '0;
        #1;
        chk("t6_idle_delay", 32'(Delay), 32'd0);

        // 5: saturating stall counter under back-to-back timeouts
        StallClear = 1'b1;
        tick();
        StallClear = 1'b0;
        ReqValid   = 4'b0011;
        repeat (70000) tick();
        chk("t5_saturated", 32'(StallCount), 32'hFFFF);
        chk("t5_delay_held", 32'(Delay), 32'd1);
        chk("t5_tflag", 32'(TimeoutFlag), 32'd1);
        StallClear = 1'b1;
        tick();
        StallClear = 1'b0;
        chk("t5_clear", 32'(StallCount), 32'd0);
        tick();
        chk("t5_resume", 32'(StallCount), 32'd1);
        ReqValid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
